// File: rtl/sha256_stream_padder.sv
// sha256_stream_padder: streaming SHA-256 message padder.
// Takes big-endian 32-bit message words and emits the padded message as
// 512-bit blocks: data, 0x80 marker, zero fill, 64-bit message bit length.
module sha256_stream_padder #(
   parameter int LEN_W = 64,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   input  logic             in_last,
   input  logic [2:0]       in_bytes,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [3:0]       out_word_idx,
   output logic             out_block_last,
   output logic             out_msg_last,
   output logic [CNT_W-1:0] block_count
);

   typedef enum logic [2:0] {
      ST_DATA,
      ST_PAD_ONE,
      ST_ZERO,
      ST_LEN_HI,
      ST_LEN_LO
   } state_t;

   state_t           state, state_nxt;
   logic [LEN_W-1:0] bit_cnt, bit_cnt_nxt;
   logic [3:0]       next_idx;      // index the next loaded word will carry
   logic             can_load;      // output register is free this cycle
   logic             load;
   logic [31:0]      load_data;
   logic [2:0]       last_bytes;    // in_bytes saturated to 4
   logic [63:0]      len64;
   state_t           after_marker;

   assign len64 = 64'(bit_cnt);

   // Next-state, input acceptance and the word to load into the output stage.
   always_comb begin
      // NOTE: every signal written here gets a default first so no latch is inferred.
      can_load     = !out_valid || out_ready;
      in_ready     = !rst && (state == ST_DATA) && can_load;
      load         = 1'b0;
      load_data    = 32'h0;
      state_nxt    = state;
      bit_cnt_nxt  = bit_cnt;
      last_bytes   = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
      // A marker at idx 13 leaves exactly room for the length; otherwise fill.
      after_marker = (next_idx == 4'd13) ? ST_LEN_HI : ST_ZERO;

      case (state)
         ST_DATA: begin
            if (in_valid && in_ready) begin
               load = 1'b1;
               if (!in_last) begin
                  load_data   = in_data;
                  bit_cnt_nxt = bit_cnt + LEN_W'(32);
               end else begin
                  bit_cnt_nxt = bit_cnt + LEN_W'({last_bytes, 3'b000});
                  state_nxt   = after_marker;
                  case (last_bytes)
                     3'd0:    load_data = 32'h8000_0000;
                     3'd1:    load_data = {in_data[31:24], 24'h80_0000};
                     3'd2:    load_data = {in_data[31:16], 16'h8000};
                     3'd3:    load_data = {in_data[31:8], 8'h80};
                     default: begin
                        load_data = in_data;
                        state_nxt = ST_PAD_ONE;
                     end
                  endcase
               end
            end
         end
         ST_PAD_ONE: begin
            if (can_load) begin
               load      = 1'b1;
               load_data = 32'h8000_0000;
               state_nxt = after_marker;
            end
         end
         ST_ZERO: begin
            if (can_load) begin
               load = 1'b1;
               if (next_idx == 4'd13) state_nxt = ST_LEN_HI;
            end
         end
         ST_LEN_HI: begin
            if (can_load) begin
               load      = 1'b1;
               load_data = len64[63:32];
               state_nxt = ST_LEN_LO;
            end
         end
         ST_LEN_LO: begin
            // The length is captured in the output word, so the counter can
            // restart now; a new message is accepted only once it transfers.
            if (can_load) begin
               load        = 1'b1;
               load_data   = len64[31:0];
               state_nxt   = ST_DATA;
               bit_cnt_nxt = '0;
            end
         end
         default: state_nxt = ST_DATA;
      endcase
   end

   // State, counters and the single registered output stage.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         state          <= ST_DATA;
         bit_cnt        <= '0;
         next_idx       <= 4'd0;
         out_valid      <= 1'b0;
         out_data       <= 32'h0;
         out_word_idx   <= 4'd0;
         out_block_last <= 1'b0;
         out_msg_last   <= 1'b0;
         block_count    <= '0;
      end else begin
         state   <= state_nxt;
         bit_cnt <= bit_cnt_nxt;
         if (load) begin
            out_valid      <= 1'b1;
            out_data       <= load_data;
            out_word_idx   <= next_idx;
            out_block_last <= (next_idx == 4'd15);
            out_msg_last   <= (state == ST_LEN_LO);
            next_idx       <= next_idx + 4'd1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (out_valid && out_ready && out_block_last) begin
            block_count <= out_msg_last ? '0 : block_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_sha256_stream_padder.sv
// tb_sha256_stream_padder: random-stimulus bench with a byte-level padding model.
module tb_sha256_stream_padder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic [2:0]  in_bytes;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_word_idx;
   logic        out_block_last;
   logic        out_msg_last;
   logic [31:0] block_count;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  msg[$];
   logic [31:0] exp_q[$];

   sha256_stream_padder #(.LEN_W(64), .CNT_W(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .in_last        (in_last),
      .in_bytes       (in_bytes),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_word_idx   (out_word_idx),
      .out_block_last (out_block_last),
      .out_msg_last   (out_msg_last),
      .block_count    (block_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // Reference padding: bytes, 0x80, zeros to 56 mod 64, 64-bit BE bit length.
   task automatic build_expected();
      logic [7:0]  p[$];
      logic [63:0] len;
      p = msg;
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      len = 64'(msg.size()) * 64'd8;
      for (int k = 7; k >= 0; k--) p.push_back(len[8*k +: 8]);
      exp_q.delete();
      for (int i = 0; i < p.size(); i += 4) exp_q.push_back({p[i], p[i+1], p[i+2], p[i+3]});
   endtask

   task automatic random_msg(input int n);
      msg.delete();
      for (int i = 0; i < n; i++) msg.push_back(8'($urandom_range(255)));
   endtask

   // Drive msg through the padder and compare every output transfer with the
   // model. Stops early once abort_after words are accepted (0 = never).
   task automatic run_msg(input int stall_pct, input int abort_after);
      int          n, nwords, wi, oi, cycles;
      logic [31:0] w, held_data;
      logic        held;
      n      = msg.size();
      nwords = (n == 0) ? 1 : (n + 3) / 4;
      wi = 0; oi = 0; cycles = 0; held = 1'b0; held_data = 32'h0;
      build_expected();
      while (oi < exp_q.size()) begin
         @(negedge clk);
         out_ready = ($urandom_range(99) >= stall_pct);
         in_last   = 1'b0;
         in_bytes  = 3'($urandom_range(4));
         in_data   = $urandom;
         in_valid  = 1'b0;
         if (wi < nwords) begin
            for (int b = 0; b < 4; b++) begin
               w = in_data;
               if (4*wi + b < n) w[31-8*b -: 8] = msg[4*wi + b];
               in_data = w;
            end
            in_valid = 1'b1;
            in_last  = (wi == nwords - 1);
            in_bytes = in_last ? 3'(n - 4*(nwords-1)) : 3'd4;
         end else if (oi < exp_q.size() - 1) begin
            // A pending word must not be taken while padding is in progress.
            in_valid = 1'b1;
         end
         #1;
         if (held) check("stall_hold", {32'h0, out_data}, {32'h0, held_data});
         if (wi >= nwords && in_valid) check("pad_ready", {63'h0, in_ready}, 64'h0);
         if (wi < nwords && in_valid && in_ready) wi++;
         if (out_valid && out_ready) begin
            check("data",      {32'h0, out_data},        {32'h0, exp_q[oi]});
            check("word_idx",  {60'h0, out_word_idx},    64'(oi % 16));
            check("block_lst", {63'h0, out_block_last},  64'(oi % 16 == 15));
            check("msg_last",  {63'h0, out_msg_last},    64'(oi == exp_q.size() - 1));
            check("blk_count", {32'h0, block_count},     64'(oi / 16));
            oi++;
         end
         held      = out_valid && !out_ready;
         held_data = out_data;
         if (abort_after > 0 && wi == abort_after) break;
         cycles++;
         if (cycles > 4000) begin
            check("timeout", 64'(oi), 64'(exp_q.size()));
            break;
         end
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      if (abort_after == 0) begin
         #1;
         check("end_count", {32'h0, block_count}, 64'h0);
         check("end_valid", {63'h0, out_valid},   64'h0);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      #1;
      check("rst_ready", {63'h0, in_ready}, 64'h0);
      @(negedge clk);
      #1;
      check("rst_valid", {63'h0, out_valid},    64'h0);
      check("rst_data",  {32'h0, out_data},     64'h0);
      check("rst_idx",   {60'h0, out_word_idx}, 64'h0);
      check("rst_mlast", {63'h0, out_msg_last}, 64'h0);
      check("rst_count", {32'h0, block_count},  64'h0);
      rst = 1'b0;
   endtask

   task automatic set_abc();
      msg.delete();
      msg.push_back(8'h61);
      msg.push_back(8'h62);
      msg.push_back(8'h63);
   endtask

   initial begin
      int lens[15] = '{0, 1, 3, 4, 52, 55, 56, 57, 59, 60, 63, 64, 119, 120, 128};
      rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; in_last = 1'b0;
      in_bytes = 3'd0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      do_reset();

      set_abc();      run_msg(0, 0);
      random_msg(0);  run_msg(0, 0);
      random_msg(55); run_msg(0, 0);
      random_msg(56); run_msg(0, 0);
      random_msg(200); run_msg(50, 0);
      foreach (lens[i]) begin
         random_msg(lens[i]);
         run_msg(30, 0);
      end
      for (int r = 0; r < 6; r++) begin
         random_msg(int'($urandom_range(150)));
         run_msg(int'($urandom_range(60)), 0);
      end

      // Abort a long message after five words, then padding must restart clean.
      random_msg(200); run_msg(20, 5);
      do_reset();
      set_abc();      run_msg(0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
